// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART RX/TX stages.
// FSM state encodings, prescale floor, parity-type codes and the
// parity generator used by both directions.
package uart_pkg;

    // Receiver FSM encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    // Smallest oversampling ratio the bit timing supports
    localparam int PRESC_MIN = 4;

    // par_type codes
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PAR_DATA_W = 8;

    // Parity bit a transmitter appends for this data byte
    function automatic logic parity_calc(input logic [PAR_DATA_W-1:0] data,
                                         input logic                  ptype);
        return (ptype == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit timing for the UART receiver.
// edge counter (0..P-1 per bit), bit counter, and the bit-value decision
// at edge_cnt == h+1.  With UART_RX_MAJORITY_EN defined the value is the
// 2-of-3 majority of samples at h-1, h, h+1; otherwise the single sample
// taken at h is used.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESC_W   = 6,
    parameter int BIT_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_s_i,
    input  logic                 clear_i,
    input  logic                 run_i,
    input  logic [PRESC_W-1:0]   presc_i,
    output logic [BIT_CNT_W-1:0] bit_cnt_o,
    output logic                 sample_pt_o,
    output logic                 bit_end_o,
    output logic                 bit_val_o
);

    logic [PRESC_W-1:0]   edge_q;
    logic [BIT_CNT_W-1:0] bit_q;
    logic [PRESC_W-1:0]   half;
    logic [PRESC_W-1:0]   half_p1;
    logic                 at_half;

    assign half    = presc_i >> 1;
    assign half_p1 = half + PRESC_W'(1);
    assign at_half = run_i && (edge_q == half);

    assign sample_pt_o = run_i && (edge_q == half_p1);
    assign bit_end_o   = run_i && (edge_q == presc_i - PRESC_W'(1));
    assign bit_cnt_o   = bit_q;

    // Edge counter wraps every P cycles and advances the bit counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else if (clear_i) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else if (run_i) begin
            if (bit_end_o) begin
                edge_q <= '0;
                bit_q  <= bit_q + BIT_CNT_W'(1);
            end else begin
                edge_q <= edge_q + PRESC_W'(1);
            end
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic tap0_q;
    logic tap1_q;
    logic [PRESC_W-1:0] half_m1;

    assign half_m1 = half - PRESC_W'(1);

    // Capture the two early taps; the third is the live line at h+1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tap0_q <= 1'b1;
            tap1_q <= 1'b1;
        end else begin
            if (run_i && (edge_q == half_m1)) tap0_q <= rx_s_i;
            if (at_half)                      tap1_q <= rx_s_i;
        end
    end

    assign bit_val_o = (tap0_q & tap1_q) | (tap0_q & rx_s_i) | (tap1_q & rx_s_i);
`else
    logic smp_q;

    // Single mid-bit sample, held for use one cycle later at h+1
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        smp_q <= 1'b1;
        else if (at_half) smp_q <= rx_s_i;
    end

    assign bit_val_o = smp_q;
`endif

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver, start + DATA_WIDTH data (LSB first) +
// optional parity + stop, oversampled by a runtime prescale.
// Holds the rx synchroniser, frame FSM, shift register and output pulses;
// bit timing lives in uart_rx_sampler.
// Optional feature macro: UART_RX_MAJORITY_EN (3-sample majority voting).
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_in,
    input  logic [PRESC_W-1:0]    prescale,
    input  logic                  PAR_En,
    input  logic                  par_type,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 3);

    logic                  rx_meta_q, rx_s_q, rx_prev_q;
    logic [2:0]            state_q, state_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic                  par_en_q, par_type_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_bad_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  data_valid_q, par_err_q, stp_err_q;

    logic                  start_det;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  sample_pt, bit_end, bit_val;

    // Two-flop synchroniser plus previous value for falling-edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign start_det = (state_q == ST_IDLE) && rx_prev_q && !rx_s_q;
    assign presc_d   = (prescale < PRESC_W'(PRESC_MIN)) ? PRESC_W'(PRESC_MIN) : prescale;

    uart_rx_sampler #(
        .PRESC_W   (PRESC_W),
        .BIT_CNT_W (BIT_CNT_W)
    ) u_sampler (
        .clk         (clk),
        .reset       (reset),
        .rx_s_i      (rx_s_q),
        .clear_i     (start_det),
        .run_i       (state_q != ST_IDLE),
        .presc_i     (presc_q),
        .bit_cnt_o   (bit_cnt),
        .sample_pt_o (sample_pt),
        .bit_end_o   (bit_end),
        .bit_val_o   (bit_val)
    );

    // Frame sequencing; bit_cnt is 1..DATA_WIDTH across the data bits
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_det) state_d = ST_START;
            ST_START:  if (sample_pt && bit_val) state_d = ST_IDLE;
                       else if (bit_end)         state_d = ST_DATA;
            ST_DATA:   if (bit_end && (bit_cnt == BIT_CNT_W'(DATA_WIDTH)))
                           state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP:   if (sample_pt) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Frame config latch, shift register, parity result and output pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q      <= PRESC_W'(PRESC_MIN);
            par_en_q     <= 1'b0;
            par_type_q   <= PAR_EVEN;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            if (start_det) begin
                presc_q    <= presc_d;
                par_en_q   <= PAR_En;
                par_type_q <= par_type;
                par_bad_q  <= 1'b0;
            end
            if ((state_q == ST_DATA) && sample_pt)
                shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
            if ((state_q == ST_PARITY) && sample_pt)
                par_bad_q <= (bit_val != parity_calc(shift_q, par_type_q));
            // Outputs are registered on the STOP sample, so they are high
            // exactly during the DONE cycle
            if ((state_q == ST_STOP) && sample_pt) begin
                stp_err_q <= !bit_val;
                par_err_q <= par_bad_q;
                if (bit_val && !par_bad_q) begin
                    data_valid_q <= 1'b1;
                    p_data_q     <= shift_q;
                end
            end
        end
    end

    assign p_data     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed + randomized frames driven at bit level;
// expectations come from the frame rules (one-count parity, stop level,
// cell timing) and a last-good-byte model.
`timescale 1ns/1ps
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic [5:0] prescale;
    logic       PAR_En;
    logic       par_type;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    uart_rx_core #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .prescale   (prescale),
        .PAR_En     (PAR_En),
        .par_type   (par_type),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every cycle data_valid is high logs one byte
    logic [7:0] got_q[$];
    int         vcyc_q[$];
    int         tot_perr = 0;
    int         tot_serr = 0;
    always @(negedge clk) begin
        if (data_valid) begin
            got_q.push_back(p_data);
            vcyc_q.push_back(cyc);
        end
        if (par_err) tot_perr <= tot_perr + 1;
        if (stp_err) tot_serr <= tot_serr + 1;
    end

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame, one line value per clock; call at posedge+1.
    // spike >= 0 inverts that bit index for a single cycle mid-bit.
    task automatic send_frame(input logic [7:0] data, input int p, input bit pen,
                              input bit ptype, input bit bad_par, input bit stop_bit,
                              input int spike, output int fall, output bit pb,
                              output bit bmid);
        logic [10:0] bits;
        int          nb;
        int          h;
        h  = p / 2;
        pb = ((($countones(data) + int'(ptype)) % 2) == 1);
        if (bad_par) pb = !pb;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = data;
        nb        = 9;
        if (pen) begin
            bits[9] = pb;
            nb      = 10;
        end
        bits[nb] = stop_bit;
        nb++;
        prescale = 6'(p);
        PAR_En   = pen;
        par_type = ptype;
        fall     = cyc;
        bmid     = 1'b0;
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < p; c++) begin
                rx_in = (i == spike && c == h + 1) ? !bits[i] : bits[i];
                // Mid-frame config changes must not affect this frame
                if (i == 1 && c == 0) begin
                    prescale = 6'($urandom_range(0, 63));
                    PAR_En   = 1'($urandom_range(0, 1));
                    par_type = 1'($urandom_range(0, 1));
                end
                if (i == 1 && c == h) bmid = busy;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] data, input int p,
                             input bit pen, input bit ptype, input bit bad_par,
                             input bit stop_bit, input int spike);
        int nv0, np0, ns0, fall, stop_idx;
        bit pb, bmid, par_ok, good;
        nv0 = got_q.size();
        np0 = tot_perr;
        ns0 = tot_serr;
        send_frame(data, p, pen, ptype, bad_par, stop_bit, spike, fall, pb, bmid);
        idle(2 * p + 4);
        stop_idx = pen ? 10 : 9;
        // Parity rule: data ones plus parity bit is even (type 0) or odd (type 1)
        par_ok = !pen || ((($countones(data) + int'(pb)) % 2) == int'(ptype));
        good   = stop_bit && par_ok;
        check({tag, "/busy_mid"}, int'(bmid), 1);
        check({tag, "/busy_end"}, int'(busy), 0);
        check({tag, "/n_valid"}, got_q.size() - nv0, int'(good));
        check({tag, "/par_err"}, tot_perr - np0, int'(pen && !par_ok));
        check({tag, "/stp_err"}, tot_serr - ns0, int'(!stop_bit));
        if (good && got_q.size() > nv0) begin
            check({tag, "/data"}, int'(got_q[nv0]), int'(data));
            // 2 sync flops + 1 edge-detect cycle + whole cells up to the stop
            // bit + (h+1) to its sample point + 1 output register
            check({tag, "/latency"}, vcyc_q[nv0] - fall, 5 + stop_idx * p + p / 2);
            last_good = data;
        end
        check({tag, "/p_data"}, int'(p_data), int'(last_good));
    endtask

    initial begin
        int fall, nv0, np0, ns0;
        bit pb, bmid;
        int p;

        reset    = 1'b1;
        rx_in    = 1'b1;
        prescale = 6'd16;
        PAR_En   = 1'b0;
        par_type = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst/p_data", int'(p_data), 0);
        check("rst/valid", int'(data_valid), 0);
        check("rst/busy", int'(busy), 0);
        check("rst/errs", int'({par_err, stp_err}), 0);
        reset = 1'b0;
        idle(5);

        run_frame("t1_p8_a5", 8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        run_frame("t2_even_ok", 8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        run_frame("t2_even_bad", 8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        run_frame("t3_stop0", 8'h81, 32, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        run_frame("t3_next", 8'h7E, 32, 1'b1, 1'b1, 1'b0, 1'b1, -1);

        // Start glitch: 3 low cycles then idle
        nv0 = got_q.size();
        np0 = tot_perr;
        ns0 = tot_serr;
        prescale = 6'd16;
        rx_in    = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rx_in = 1'b1;
        @(posedge clk);
        #1;
        check("t4/busy_start", int'(busy), 1);
        idle(40);
        check("t4/busy_end", int'(busy), 0);
        check("t4/no_pulse", (got_q.size() - nv0) + (tot_perr - np0) + (tot_serr - ns0), 0);

        // Back-to-back frames, no idle gap
        nv0 = got_q.size();
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, fall, pb, bmid);
        send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, fall, pb, bmid);
        idle(20);
        check("t5/n_valid", got_q.size() - nv0, 2);
        if (got_q.size() >= nv0 + 2) begin
            check("t5/byte0", int'(got_q[nv0]), 8'h55);
            check("t5/byte1", int'(got_q[nv0 + 1]), 8'hAA);
        end
        last_good = 8'hAA;

        // Reset in the middle of data bit 4
        p        = 8;
        prescale = 6'(p);
        PAR_En   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < p; c++) begin
                rx_in = (i == 0) ? 1'b0 : 1'b1;
                @(posedge clk);
                #1;
            end
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("t6/busy_pre", int'(busy), 1);
        reset = 1'b1;
        #1;
        check("t6/p_data", int'(p_data), 0);
        check("t6/busy", int'(busy), 0);
        check("t6/pulses", int'({data_valid, par_err, stp_err}), 0);
        last_good = 8'h00;
        rx_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(10);
        run_frame("t6_after", 8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle spike on data bit 3 centre must be voted out
        run_frame("t7_spike", 8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1, 4);
`endif

        // Randomized frames
        for (int k = 0; k < 10; k++) begin
            case ($urandom_range(0, 2))
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            run_frame($sformatf("rnd%0d", k), 8'($urandom_range(0, 255)), p,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), -1);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
